// File: rtl/autosa_csc_csb2reg.sv
// autosa_csc_csb2reg
// ------------------
// CSB-side initiator for the CSC register file. It accepts one configuration
// bus request at a time, decodes the unit base and register offset, then
// drives the shared register interface that feeds the single register group
// and the two ping-pong dual groups. Read data and non-posted write acks
// return on a valid/ready response channel.
//
// Ports
//   autosa_core_clk, autosa_core_rstn      clock, async active-low reset
//   req_pvld / req_prdy                    request handshake (ready only in IDLE)
//   req_addr[21:0]                         word address, byte addr = {req_addr, 2'b00}
//   req_wdat[31:0], req_write, req_nposted write data, direction, ack request
//   resp_valid / resp_ready                response handshake
//   resp_rdat[31:0], resp_is_wr, resp_error response payload
//   producer                               dual-group pointer (0 -> d0, 1 -> d1)
//   reg_offset[11:0], reg_wr_data[31:0]    shared register interface
//   s/d0/d1_reg_wr_en                      per-group one-cycle write strobes
//   s/d0/d1_reg_rd_data[31:0]              per-group read data (combinational)
//
// Accept in cycle N: ACCESS in N+1 (write strobe or read sample), RESP from
// N+2 for reads and non-posted writes; posted writes return to IDLE at N+2.

module autosa_csc_csb2reg #(
  parameter logic [11:0] UNIT_BASE    = 12'h006,
  parameter logic [11:0] SINGLE_LIMIT = 12'h008,
  parameter logic [11:0] DUAL_LIMIT   = 12'h100
) (
  input  logic        autosa_core_clk,
  input  logic        autosa_core_rstn,
  input  logic        req_pvld,
  output logic        req_prdy,
  input  logic [21:0] req_addr,
  input  logic [31:0] req_wdat,
  input  logic        req_write,
  input  logic        req_nposted,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdat,
  output logic        resp_is_wr,
  output logic        resp_error,
  input  logic        producer,
  output logic [11:0] reg_offset,
  output logic [31:0] reg_wr_data,
  output logic        s_reg_wr_en,
  output logic        d0_reg_wr_en,
  output logic        d1_reg_wr_en,
  input  logic [31:0] s_reg_rd_data,
  input  logic [31:0] d0_reg_rd_data,
  input  logic [31:0] d1_reg_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e state;

  // Request attributes captured at accept time; the in-flight access uses
  // only these, so later changes on req_* or producer cannot disturb it.
  logic write_q;
  logic nposted_q;
  logic sel_q;
  logic hit_q;

  // Decode of the request currently offered on the bus.
  logic [23:0] req_byte_addr;
  logic [11:0] req_offset;
  logic        req_hit;
  logic        req_single;
  logic        accept;

  assign req_byte_addr = {req_addr, 2'b00};
  assign req_offset    = req_byte_addr[11:0];
  assign req_hit       = (req_byte_addr[23:12] == UNIT_BASE) && (req_offset < DUAL_LIMIT);
  assign req_single    = (req_offset < SINGLE_LIMIT);
  assign accept        = req_pvld && req_prdy;

  // Read-data select for the latched access. A miss reads as zero.
  logic [31:0] rd_mux;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_mux = '0;
    if (hit_q) begin
      if (reg_offset < SINGLE_LIMIT) rd_mux = s_reg_rd_data;
      else if (sel_q)                rd_mux = d1_reg_rd_data;
      else                           rd_mux = d0_reg_rd_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; a later
  // assignment in the same clock simply overrides an earlier default.
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state        <= IDLE;
      req_prdy     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdat    <= '0;
      resp_is_wr   <= 1'b0;
      resp_error   <= 1'b0;
      reg_offset   <= '0;
      reg_wr_data  <= '0;
      s_reg_wr_en  <= 1'b0;
      d0_reg_wr_en <= 1'b0;
      d1_reg_wr_en <= 1'b0;
      write_q      <= 1'b0;
      nposted_q    <= 1'b0;
      sel_q        <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      // Write strobes are single-cycle pulses: cleared unless set below.
      s_reg_wr_en  <= 1'b0;
      d0_reg_wr_en <= 1'b0;
      d1_reg_wr_en <= 1'b0;

      case (state)
        IDLE: begin
          req_prdy <= 1'b1;
          if (accept) begin
            reg_offset   <= req_offset;
            reg_wr_data  <= req_wdat;
            write_q      <= req_write;
            nposted_q    <= req_nposted;
            sel_q        <= producer;
            hit_q        <= req_hit;
            // Strobe is registered here so it is high exactly during ACCESS.
            s_reg_wr_en  <= req_write && req_hit && req_single;
            d0_reg_wr_en <= req_write && req_hit && !req_single && !producer;
            d1_reg_wr_en <= req_write && req_hit && !req_single && producer;
            req_prdy     <= 1'b0;
            state        <= ACCESS;
          end
        end

        ACCESS: begin
          if (!write_q || nposted_q) begin
            resp_valid <= 1'b1;
            resp_is_wr <= write_q;
            resp_error <= !hit_q;
            resp_rdat  <= write_q ? 32'h0 : rd_mux;
            state      <= RESP;
          end else begin
            // Posted write: no response, even on a decode miss.
            req_prdy <= 1'b1;
            state    <= IDLE;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_prdy   <= 1'b1;
            state      <= IDLE;
          end
        end

        default: begin
          req_prdy   <= 1'b0;
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_autosa_csc_csb2reg.sv
// Directed testbench for autosa_csc_csb2reg. Inputs change 1 time unit after
// the rising edge and outputs are sampled there as well, away from the edge.

module tb_autosa_csc_csb2reg;

  logic        autosa_core_clk;
  logic        autosa_core_rstn;
  logic        req_pvld;
  logic        req_prdy;
  logic [21:0] req_addr;
  logic [31:0] req_wdat;
  logic        req_write;
  logic        req_nposted;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdat;
  logic        resp_is_wr;
  logic        resp_error;
  logic        producer;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        s_reg_wr_en;
  logic        d0_reg_wr_en;
  logic        d1_reg_wr_en;
  logic [31:0] s_reg_rd_data;
  logic [31:0] d0_reg_rd_data;
  logic [31:0] d1_reg_rd_data;

  int errors = 0;
  int checks = 0;

  autosa_csc_csb2reg dut (
    .autosa_core_clk (autosa_core_clk),
    .autosa_core_rstn(autosa_core_rstn),
    .req_pvld        (req_pvld),
    .req_prdy        (req_prdy),
    .req_addr        (req_addr),
    .req_wdat        (req_wdat),
    .req_write       (req_write),
    .req_nposted     (req_nposted),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdat       (resp_rdat),
    .resp_is_wr      (resp_is_wr),
    .resp_error      (resp_error),
    .producer        (producer),
    .reg_offset      (reg_offset),
    .reg_wr_data     (reg_wr_data),
    .s_reg_wr_en     (s_reg_wr_en),
    .d0_reg_wr_en    (d0_reg_wr_en),
    .d1_reg_wr_en    (d1_reg_wr_en),
    .s_reg_rd_data   (s_reg_rd_data),
    .d0_reg_rd_data  (d0_reg_rd_data),
    .d1_reg_rd_data  (d1_reg_rd_data)
  );

  initial autosa_core_clk = 1'b0;
  always #5 autosa_core_clk = ~autosa_core_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge autosa_core_clk);
    #1;
  endtask

  // Offers one request; returns in cycle N+1 with req_pvld dropped.
  task automatic issue(input logic [23:0] byte_addr, input logic [31:0] wdat,
                       input logic wr, input logic np);
    int n;
    n = 0;
    while (req_prdy !== 1'b1 && n < 20) begin
      next_cycle();
      n++;
    end
    check("ready_before_issue", {31'b0, req_prdy}, 32'h1);
    req_pvld    = 1'b1;
    req_addr    = byte_addr[23:2];
    req_wdat    = wdat;
    req_write   = wr;
    req_nposted = np;
    next_cycle();
    req_pvld    = 1'b0;
  endtask

  task automatic check_strobes(input string tag, input logic [2:0] exp);
    check(tag, {29'b0, s_reg_wr_en, d0_reg_wr_en, d1_reg_wr_en}, {29'b0, exp});
  endtask

  initial begin
    autosa_core_rstn = 1'b0;
    req_pvld       = 1'b0;
    req_addr       = '0;
    req_wdat       = '0;
    req_write      = 1'b0;
    req_nposted    = 1'b0;
    resp_ready     = 1'b1;
    producer       = 1'b0;
    s_reg_rd_data  = 32'h0002_0001;
    d0_reg_rd_data = 32'h0000_d0d0;
    d1_reg_rd_data = 32'h0000_d1d1;

    // Reset state
    repeat (3) next_cycle();
    check("rst_prdy", {31'b0, req_prdy}, 32'h0);
    check("rst_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_rdat", resp_rdat, 32'h0);
    check("rst_flags", {30'b0, resp_is_wr, resp_error}, 32'h0);
    check("rst_offset", {20'b0, reg_offset}, 32'h0);
    check("rst_wdata", reg_wr_data, 32'h0);
    check_strobes("rst_strobes", 3'b000);
    autosa_core_rstn = 1'b1;
    check("prdy_before_first_clk", {31'b0, req_prdy}, 32'h0);
    next_cycle();
    check("prdy_after_release", {31'b0, req_prdy}, 32'h1);

    // Posted write to single group, byte 0x6004
    issue(24'h006004, 32'h1, 1'b1, 1'b0);
    check_strobes("pw_strobe_n1", 3'b100);
    check("pw_offset", {20'b0, reg_offset}, 32'h004);
    check("pw_wdata", reg_wr_data, 32'h1);
    check("pw_prdy_n1", {31'b0, req_prdy}, 32'h0);
    next_cycle();
    check_strobes("pw_strobe_n2", 3'b000);
    check("pw_no_resp", {31'b0, resp_valid}, 32'h0);
    check("pw_prdy_n2", {31'b0, req_prdy}, 32'h1);
    check("pw_offset_hold", {20'b0, reg_offset}, 32'h004);

    // Read single group, byte 0x6000
    issue(24'h006000, 32'h0, 1'b0, 1'b0);
    check_strobes("rd_strobe_n1", 3'b000);
    check("rd_offset", {20'b0, reg_offset}, 32'h000);
    check("rd_valid_n1", {31'b0, resp_valid}, 32'h0);
    next_cycle();
    check("rd_valid_n2", {31'b0, resp_valid}, 32'h1);
    check("rd_rdat", resp_rdat, 32'h0002_0001);
    check("rd_flags", {30'b0, resp_is_wr, resp_error}, 32'h0);
    next_cycle();
    check("rd_valid_n3", {31'b0, resp_valid}, 32'h0);
    check("rd_prdy_n3", {31'b0, req_prdy}, 32'h1);

    // Non-posted write to dual group, producer = 1 then producer = 0.
    // Producer flips right after accept and must not affect the access.
    for (int p = 1; p >= 0; p--) begin
      producer = p[0];
      issue(24'h006010, 32'hcafe_0000 | p, 1'b1, 1'b1);
      producer = ~p[0];
      check_strobes("npw_strobe_n1", (p == 1) ? 3'b001 : 3'b010);
      check("npw_offset", {20'b0, reg_offset}, 32'h010);
      check("npw_wdata", reg_wr_data, 32'hcafe_0000 | p);
      next_cycle();
      check_strobes("npw_strobe_n2", 3'b000);
      check("npw_valid", {31'b0, resp_valid}, 32'h1);
      check("npw_rdat", resp_rdat, 32'h0);
      check("npw_flags", {30'b0, resp_is_wr, resp_error}, 32'h2);
      next_cycle();
      check("npw_done", {31'b0, resp_valid}, 32'h0);
    end
    producer = 1'b0;

    // Decode misses: base miss 0x7004, offset miss 0x6200 (reads), then a
    // non-posted write miss at 0x6200.
    issue(24'h007004, 32'h0, 1'b0, 1'b0);
    check_strobes("miss_base_strobe", 3'b000);
    next_cycle();
    check("miss_base_valid", {31'b0, resp_valid}, 32'h1);
    check("miss_base_rdat", resp_rdat, 32'h0);
    check("miss_base_flags", {30'b0, resp_is_wr, resp_error}, 32'h1);
    next_cycle();
    issue(24'h006200, 32'h0, 1'b0, 1'b0);
    check_strobes("miss_off_strobe", 3'b000);
    next_cycle();
    check("miss_off_rdat", resp_rdat, 32'h0);
    check("miss_off_flags", {30'b0, resp_is_wr, resp_error}, 32'h1);
    next_cycle();
    issue(24'h006200, 32'hffff_ffff, 1'b1, 1'b1);
    check_strobes("miss_wr_strobe", 3'b000);
    next_cycle();
    check("miss_wr_flags", {30'b0, resp_is_wr, resp_error}, 32'h3);
    next_cycle();

    // Response backpressure on a dual-group read (d0, byte 0x6020)
    resp_ready     = 1'b0;
    d0_reg_rd_data = 32'h0000_1234;
    issue(24'h006020, 32'h0, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      d0_reg_rd_data = 32'h5555_0000 + i;
      check("bp_valid", {31'b0, resp_valid}, 32'h1);
      check("bp_rdat", resp_rdat, 32'h0000_1234);
      check("bp_prdy", {31'b0, req_prdy}, 32'h0);
      next_cycle();
    end
    resp_ready = 1'b1;
    next_cycle();
    check("bp_release_valid", {31'b0, resp_valid}, 32'h0);
    check("bp_release_prdy", {31'b0, req_prdy}, 32'h1);

    // Reset during ACCESS of a non-posted write
    issue(24'h006004, 32'h77, 1'b1, 1'b1);
    check_strobes("rst_mid_strobe_before", 3'b100);
    autosa_core_rstn = 1'b0;
    #1;
    check_strobes("rst_mid_strobe_cut", 3'b000);
    check("rst_mid_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_mid_prdy", {31'b0, req_prdy}, 32'h0);
    check("rst_mid_offset", {20'b0, reg_offset}, 32'h0);
    next_cycle();
    check("rst_mid_no_resp", {31'b0, resp_valid}, 32'h0);
    autosa_core_rstn = 1'b1;
    next_cycle();
    check("rst_after_prdy", {31'b0, req_prdy}, 32'h1);
    d1_reg_rd_data = 32'hbeef_0001;
    producer       = 1'b1;
    issue(24'h0060fc, 32'h0, 1'b0, 1'b0);
    next_cycle();
    check("rst_after_valid", {31'b0, resp_valid}, 32'h1);
    check("rst_after_rdat", resp_rdat, 32'hbeef_0001);
    check("rst_after_flags", {30'b0, resp_is_wr, resp_error}, 32'h0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
